// File: rtl/relobi_rr_arbiter_pkg.sv
// rtl/relobi_rr_arbiter_pkg.sv - OBI channel types and index helpers for the round-robin arbiter
//
// Purpose: shared OBI request/response structs, their flattened widths and
// the index-width helper used by the arbiter and its index FIFO.
package relobi_rr_arbiter_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
  } obi_a_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  localparam int unsigned ReqWidth = $bits(obi_req_t);
  localparam int unsigned RspWidth = $bits(obi_rsp_t);

  // Width of an index into n items; a single item still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relobi_rr_arbiter_fifo.sv
// rtl/relobi_rr_arbiter_fifo.sv - index FIFO recording the owner of each outstanding transaction
//
// Purpose: non-fall-through FIFO of requester indices.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  enqueue an index (ignored when full)
//   pop_i          dequeue the head (ignored when empty)
//   data_o         head entry
//   empty_o        no entries stored
//   usage_o        number of entries stored
module relobi_rr_arbiter_fifo #(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned Width = 1,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != CntW'(Depth));
  assign pop_ok  = pop_i && (cnt_q != '0);

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/relobi_rr_arbiter.sv
// rtl/relobi_rr_arbiter.sv - round-robin OBI arbiter with TMR pointer and in-order response routing
//
// Purpose: shares one OBI manager port between NumSbrPorts requesters.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   sbr_ports_req_i  packed obi_req_t per requester
//   sbr_ports_rsp_o  packed obi_rsp_t per requester
//   mgr_port_req_o   packed obi_req_t to the shared subordinate
//   mgr_port_rsp_i   packed obi_rsp_t from the shared subordinate
//   fault_o          [0] pointer copies disagree, [1] rvalid with nothing outstanding
module relobi_rr_arbiter
  import relobi_rr_arbiter_pkg::*;
#(
  parameter bit          UseRReady   = 1'b0,
  parameter int unsigned NumSbrPorts = 2,
  parameter int unsigned MaxTrans    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumSbrPorts-1:0][ReqWidth-1:0] sbr_ports_req_i,
  output logic [NumSbrPorts-1:0][RspWidth-1:0] sbr_ports_rsp_o,
  output logic [ReqWidth-1:0]                  mgr_port_req_o,
  input  logic [RspWidth-1:0]                  mgr_port_rsp_i,
  output logic [1:0]                           fault_o
);

  localparam int unsigned IdxW = idx_width(NumSbrPorts);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  typedef logic [IdxW-1:0] idx_t;

  obi_req_t sbr_req [NumSbrPorts];
  obi_rsp_t sbr_rsp [NumSbrPorts];
  obi_req_t mgr_req;
  obi_rsp_t mgr_rsp;

  logic [NumSbrPorts-1:0] req_vec;
  idx_t                   arb_idx, sel, locked_idx_q, head, ptr_voted;
  logic                   lock_q, ptr_fault, any_req, full, empty, handshake, pop;
  logic [CntW-1:0]        cnt;

  for (genvar g = 0; g < NumSbrPorts; g++) begin : gen_ports
    assign sbr_req[g]         = sbr_ports_req_i[g];
    assign sbr_ports_rsp_o[g] = sbr_rsp[g];
    assign req_vec[g]         = sbr_req[g].req;
  end
  assign mgr_port_req_o = mgr_req;
  assign mgr_rsp        = mgr_port_rsp_i;

  if (NumSbrPorts > 1) begin : gen_ptr
    idx_t ptr0_q, ptr1_q, ptr2_q, ptr_next, j;
    logic found;

    assign ptr_voted = (ptr0_q & ptr1_q) | (ptr0_q & ptr2_q) | (ptr1_q & ptr2_q);
    assign ptr_fault = (ptr0_q != ptr1_q) || (ptr1_q != ptr2_q);

    // First requester at or after the voted pointer, wrapping around.
    always_comb begin
      arb_idx = ptr_voted;
      found   = 1'b0;
      j       = '0;
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
        j = idx_t'((32'(ptr_voted) + i) % NumSbrPorts);
        if (!found && req_vec[j]) begin
          arb_idx = j;
          found   = 1'b1;
        end
      end
    end

    // Every edge rewrites all copies, which scrubs a single upset copy.
    assign ptr_next = !handshake ? ptr_voted :
                      (sel == idx_t'(NumSbrPorts - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ptr0_q <= '0;
        ptr1_q <= '0;
        ptr2_q <= '0;
      end else begin
        ptr0_q <= ptr_next;
        ptr1_q <= ptr_next;
        ptr2_q <= ptr_next;
      end
    end
  end else begin : gen_no_ptr
    assign ptr_voted = '0;
    assign ptr_fault = 1'b0;
    assign arb_idx   = '0;
  end

  // A presented-but-ungranted request pins the selection until its handshake.
  assign sel       = lock_q ? locked_idx_q : arb_idx;
  assign any_req   = |req_vec;
  assign full      = (cnt == CntW'(MaxTrans));
  assign handshake = mgr_req.req && mgr_rsp.gnt;
  assign pop       = mgr_rsp.rvalid && mgr_req.rready && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
    end else if (handshake) begin
      lock_q <= 1'b0;
    end else if (mgr_req.req) begin
      lock_q       <= 1'b1;
      locked_idx_q <= sel;
    end
  end

  relobi_rr_arbiter_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (empty),
    .usage_o (cnt)
  );

  always_comb begin
    mgr_req     = '0;
    mgr_req.req = any_req && !full;
    mgr_req.a   = sbr_req[sel].a;
    // With nothing outstanding the beat has no owner, so it is always accepted and dropped.
    mgr_req.rready = (!UseRReady || empty) ? 1'b1 : sbr_req[head].rready;
  end

  always_comb begin
    for (int i = 0; i < NumSbrPorts; i++) begin
      sbr_rsp[i]        = '0;
      sbr_rsp[i].r      = mgr_rsp.r;
      sbr_rsp[i].gnt    = (idx_t'(i) == sel) && handshake;
      sbr_rsp[i].rvalid = (idx_t'(i) == head) && mgr_rsp.rvalid && !empty;
    end
  end

  assign fault_o = {mgr_rsp.rvalid && empty, ptr_fault};

endmodule

// File: tb/tb_relobi_rr_arbiter.sv
// tb/tb_relobi_rr_arbiter.sv - directed self-checking bench for relobi_rr_arbiter
module tb_relobi_rr_arbiter;
  import relobi_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obi_req_t sreq0, sreq1, mreq;
  obi_rsp_t mrsp, srsp0, srsp1;
  logic [1:0][ReqWidth-1:0] sbr_req_bus;
  logic [1:0][RspWidth-1:0] sbr_rsp_bus;
  logic [ReqWidth-1:0]      mgr_req_bus;
  logic [RspWidth-1:0]      mgr_rsp_bus;
  logic [1:0]               fault;
  logic [1:0]               gnt_vec, rv_vec;

  assign sbr_req_bus[0] = sreq0;
  assign sbr_req_bus[1] = sreq1;
  assign mgr_rsp_bus    = mrsp;
  assign mreq           = mgr_req_bus;
  assign srsp0          = sbr_rsp_bus[0];
  assign srsp1          = sbr_rsp_bus[1];
  assign gnt_vec        = {srsp1.gnt, srsp0.gnt};
  assign rv_vec         = {srsp1.rvalid, srsp0.rvalid};

  relobi_rr_arbiter #(
    .UseRReady   (1'b1),
    .NumSbrPorts (2),
    .MaxTrans    (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .sbr_ports_req_i (sbr_req_bus),
    .sbr_ports_rsp_o (sbr_rsp_bus),
    .mgr_port_req_o  (mgr_req_bus),
    .mgr_port_rsp_i  (mgr_rsp_bus),
    .fault_o         (fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sreq0 = '0;
    sreq1 = '0;
    mrsp  = '0;
    step();
    step();
    #2;
    check("rst_mgr_req", mreq.req, 0);
    check("rst_mgr_addr", mreq.a.addr, 0);
    check("rst_rsp0", srsp0, 0);
    check("rst_rsp1", srsp1, 0);
    check("rst_fault", fault, 0);
    check("rst_cnt", dut.cnt, 0);
    check("rst_lock", dut.lock_q, 0);
    rst_n = 1'b1;
    step();

    sreq0.a.addr = 32'h100;
    sreq1.a.addr = 32'h200;
    sreq0.rready = 1'b1;
    sreq1.rready = 1'b1;
    mrsp.r.rdata = 32'hCAFE;

    // Both requesting, gnt always: grants and responses alternate.
    mrsp.gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sreq0.req   = (k < 4);
      sreq1.req   = (k < 4);
      mrsp.rvalid = (k >= 1);
      #2;
      if (k < 4) begin
        check("alt_addr", mreq.a.addr, (k % 2 == 0) ? 32'h100 : 32'h200);
        check("alt_gnt", gnt_vec, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (k >= 1) check("alt_rvalid", rv_vec, (k % 2 == 1) ? 2'b01 : 2'b10);
      if (k == 2) check("r_bcast", srsp1.r.rdata, 32'hCAFE);
      step();
    end
    mrsp.rvalid = 1'b0;
    #2;
    check("alt_cnt", dut.cnt, 0);

    // Port1 waits for gnt; port0 arriving later must not steal the A channel.
    step();
    mrsp.gnt  = 1'b0;
    sreq1.req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("lock_addr", mreq.a.addr, 32'h200);
      check("lock_gnt", gnt_vec, 2'b00);
      step();
    end
    sreq0.req = 1'b1;
    #2;
    check("lock_hold_addr", mreq.a.addr, 32'h200);
    check("lock_q", dut.lock_q, 1);
    step();
    mrsp.gnt = 1'b1;
    #2;
    check("lock_gnt_p1", gnt_vec, 2'b10);
    step();
    sreq1.req = 1'b0;
    #2;
    check("next_addr_p0", mreq.a.addr, 32'h100);
    check("next_gnt_p0", gnt_vec, 2'b01);
    step();
    sreq0.req   = 1'b0;
    mrsp.gnt    = 1'b0;
    mrsp.rvalid = 1'b1;
    #2;
    check("lock_rsp_p1", rv_vec, 2'b10);
    step();
    #2;
    check("lock_rsp_p0", rv_vec, 2'b01);
    step();
    mrsp.rvalid = 1'b0;

    // Fill to MaxTrans, then one pop re-opens the request path a cycle later.
    sreq0.req = 1'b1;
    mrsp.gnt  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("fill_gnt", gnt_vec, 2'b01);
      step();
    end
    #2;
    check("full_req", mreq.req, 0);
    check("full_gnt", gnt_vec, 2'b00);
    check("full_cnt", dut.cnt, 4);
    step();
    mrsp.rvalid = 1'b1;
    #2;
    check("full_pop_req", mreq.req, 0);
    check("full_pop_rv", rv_vec, 2'b01);
    step();
    mrsp.rvalid = 1'b0;
    #2;
    check("refill_req", mreq.req, 1);
    check("refill_gnt", gnt_vec, 2'b01);
    step();
    sreq0.req = 1'b0;
    mrsp.gnt  = 1'b0;
    check("refill_cnt", dut.cnt, 4);

    // Head requester stalls rready for two cycles.
    sreq0.rready = 1'b0;
    mrsp.rvalid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      check("stall_rready", mreq.rready, 0);
      check("stall_rv", rv_vec, 2'b01);
      step();
      check("stall_cnt", dut.cnt, 4);
    end
    sreq0.rready = 1'b1;
    #2;
    check("unstall_rready", mreq.rready, 1);
    step();
    check("unstall_cnt", dut.cnt, 3);
    repeat (3) step();
    mrsp.rvalid = 1'b0;
    check("drain_cnt", dut.cnt, 0);

    // Three outstanding plus a held lock, then asynchronous reset.
    sreq0.req = 1'b1;
    mrsp.gnt  = 1'b1;
    repeat (3) step();
    sreq0.req = 1'b0;
    sreq1.req = 1'b1;
    mrsp.gnt  = 1'b0;
    step();
    check("pre_rst_cnt", dut.cnt, 3);
    check("pre_rst_lock", dut.lock_q, 1);
    check("pre_rst_ptr", dut.gen_ptr.ptr0_q, 1);
    sreq1.req = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("arst_cnt", dut.cnt, 0);
    check("arst_lock", dut.lock_q, 0);
    check("arst_ptr0", dut.gen_ptr.ptr0_q, 0);
    check("arst_ptr2", dut.gen_ptr.ptr2_q, 0);
    rst_n = 1'b1;
    step();

    // Late response after reset has no owner.
    mrsp.rvalid = 1'b1;
    #2;
    check("unexp_fault", fault, 2'b10);
    check("unexp_rready", mreq.rready, 1);
    check("unexp_rv", rv_vec, 2'b00);
    step();
    mrsp.rvalid = 1'b0;
    #2;
    check("unexp_fault_clr", fault, 2'b00);
    step();

    // Upset one pointer copy; vote keeps arbitration at 0 and the edge scrubs it.
    sreq0.req = 1'b1;
    sreq1.req = 1'b1;
    force dut.gen_ptr.ptr2_q = 1'b1;
    #2;
    check("tmr_fault", fault, 2'b01);
    check("tmr_addr", mreq.a.addr, 32'h100);
    sreq0.req = 1'b0;
    sreq1.req = 1'b0;
    release dut.gen_ptr.ptr2_q;
    step();
    check("tmr_scrub", dut.gen_ptr.ptr2_q, 0);
    check("tmr_fault_clr", fault, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
